my_dmux_stream: RTL and testbench

- Registered, flow-controlled demultiplexer: one input stream is routed by `in_sel` to one of N output lanes.
- Each lane has a one-entry holding register with a valid/ready handshake.
- It is the sequential counterpart of the combinational mux: it fans out where the mux fans in.
- Sits between a single producer (e.g. the CPU write path) and N independent consumers (memory-mapped devices).

---
 rtl/my_dmux_stream.sv | 85 ++++++++
 tb/tb_my_dmux_stream.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/my_dmux_stream.sv
// my_dmux_stream: registered 1-to-N stream demux with a one-entry holding register per lane.
// Defining MY_DMUX_STREAM_STATS_EN adds the xfer_count accept counter port.
module my_dmux_stream #(
    parameter int WIDTH    = 16,
    parameter int SEL_BITS = 1,
    localparam int N       = 2**SEL_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_BITS-1:0]  in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N*WIDTH-1:0]   out_data,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready
`ifdef MY_DMUX_STREAM_STATS_EN
    ,
    output logic [15:0]          xfer_count
`endif
);

    // Handshake: a word moves on a rising edge exactly when valid and ready are both
    // high in that cycle; ready never looks at valid, and a held word stays put until taken.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    // Per-lane FSM state, kept as a named array so checkers can bind to it directly.
    lane_state_t lane_state [N];
    logic        accept;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            out_valid[k] = (lane_state[k] == FULL);
        end
    end

    // A full lane still accepts when its consumer drains in the same cycle.
    always_comb begin
        in_ready = !out_valid[in_sel] | out_ready[in_sel];
        accept   = in_valid & in_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                lane_state[k] <= EMPTY;
            end
            out_data <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                case (lane_state[k])
                    EMPTY: begin
                        if (accept && (in_sel == SEL_BITS'(k))) begin
                            lane_state[k]                <= FULL;
                            out_data[k*WIDTH +: WIDTH]   <= in_data;
                        end
                    end
                    FULL: begin
                        if (accept && (in_sel == SEL_BITS'(k))) begin
                            out_data[k*WIDTH +: WIDTH]   <= in_data;
                        end else if (out_ready[k]) begin
                            lane_state[k]                <= EMPTY;
                        end
                    end
                    default: lane_state[k] <= EMPTY;
                endcase
            end
        end
    end

`ifdef MY_DMUX_STREAM_STATS_EN
    // Free-running accept counter; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_count <= '0;
        end else if (accept) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_my_dmux_stream.sv
// Self-checking bench for my_dmux_stream (WIDTH=16, SEL_BITS=1) with a per-lane scoreboard.
// Covers the xfer_count port when MY_DMUX_STREAM_STATS_EN is defined.
module tb_my_dmux_stream;

    localparam int WIDTH    = 16;
    localparam int SEL_BITS = 1;
    localparam int N        = 2;

    logic                clk;
    logic                reset;
    logic [WIDTH-1:0]    in_data;
    logic [SEL_BITS-1:0] in_sel;
    logic                in_valid;
    logic                in_ready;
    logic [N*WIDTH-1:0]  out_data;
    logic [N-1:0]        out_valid;
    logic [N-1:0]        out_ready;
`ifdef MY_DMUX_STREAM_STATS_EN
    logic [15:0]         xfer_count;
`endif

    my_dmux_stream #(
        .WIDTH    (WIDTH),
        .SEL_BITS (SEL_BITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MY_DMUX_STREAM_STATS_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and reference model
    logic [WIDTH-1:0] exp_q0[$];
    logic [WIDTH-1:0] exp_q1[$];
    logic             mvalid [N];
    logic [WIDTH-1:0] mdata  [N];
    logic [15:0]      mcount;
    int               err_cnt;
    int               chk_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            mvalid[k] = 1'b0;
            mdata[k]  = '0;
        end
        exp_q0.delete();
        exp_q1.delete();
        mcount = '0;
    endtask

    // Drives one cycle, checks the DUT state against the model, then advances the model.
    task automatic cycle(input logic vld, input logic sel, input logic [WIDTH-1:0] data,
                         input logic [N-1:0] ordy);
        logic             exp_ready;
        logic [WIDTH-1:0] exp_w;
        in_valid  = vld;
        in_sel    = sel;
        in_data   = data;
        out_ready = ordy;
        #1;
        exp_ready = !mvalid[sel] || ordy[sel];
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("out_valid", 64'(out_valid), 64'({mvalid[1], mvalid[0]}));
        check("out_data", 64'(out_data), 64'({mdata[1], mdata[0]}));
`ifdef MY_DMUX_STREAM_STATS_EN
        check("xfer_count", 64'(xfer_count), 64'(mcount));
`endif
        if (reset) begin
            model_clear();
        end else begin
            if (mvalid[0] && ordy[0] && exp_q0.size() > 0) begin
                exp_w = exp_q0.pop_front();
                check("drain0", 64'(out_data[WIDTH-1:0]), 64'(exp_w));
            end
            if (mvalid[1] && ordy[1] && exp_q1.size() > 0) begin
                exp_w = exp_q1.pop_front();
                check("drain1", 64'(out_data[2*WIDTH-1:WIDTH]), 64'(exp_w));
            end
            for (int k = 0; k < N; k++) begin
                if (mvalid[k] && ordy[k]) mvalid[k] = 1'b0;
            end
            if (vld && exp_ready) begin
                if (sel == 1'b0) exp_q0.push_back(data);
                else             exp_q1.push_back(data);
                mdata[sel]  = data;
                mvalid[sel] = 1'b1;
                mcount      = mcount + 16'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        err_cnt   = 0;
        chk_cnt   = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values, then load both lanes with consumers stalled
        cycle(1'b0, 1'b0, 16'h0000, 2'b00);
        cycle(1'b1, 1'b0, 16'hA5A5, 2'b00);
        cycle(1'b1, 1'b1, 16'h5A5A, 2'b00);
        check("lane0_A5A5", 64'(out_data[15:0]), 64'h0000_0000_0000_A5A5);
        check("lane1_5A5A", 64'(out_data[31:16]), 64'h0000_0000_0000_5A5A);
        cycle(1'b0, 1'b0, 16'h0000, 2'b00);

        // Per-lane back-pressure: lane0 stalled blocks sel=0 only
        cycle(1'b0, 1'b0, 16'h0000, 2'b10);
        cycle(1'b1, 1'b0, 16'h1111, 2'b00);
        check("lane0_held", 64'(out_data[15:0]), 64'h0000_0000_0000_A5A5);
        cycle(1'b1, 1'b1, 16'h2222, 2'b00);
        check("lane1_2222", 64'(out_data[31:16]), 64'h0000_0000_0000_2222);

        // Replace-on-drain with no bubble, then drain to empty
        cycle(1'b0, 1'b0, 16'h0000, 2'b11);
        cycle(1'b1, 1'b0, 16'h0001, 2'b00);
        cycle(1'b1, 1'b0, 16'h0002, 2'b01);
        check("lane0_0002", 64'(out_data[15:0]), 64'h0000_0000_0000_0002);
        check("lane0_full", 64'(out_valid[0]), 64'h1);
        cycle(1'b0, 1'b0, 16'h0000, 2'b01);
        check("lane0_empty", 64'(out_valid[0]), 64'h0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom), 2'($urandom_range(0, 3)));
        end

        // Reset collides with an accept and a drain while both lanes are full
        cycle(1'b0, 1'b0, 16'h0000, 2'b00);
        cycle(1'b1, 1'b0, 16'h1234, 2'b00);
        cycle(1'b1, 1'b1, 16'h5678, 2'b00);
        reset = 1'b1;
        cycle(1'b1, 1'b0, 16'hBEEF, 2'b01);
        reset = 1'b0;
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_data", 64'(out_data), 64'h0);
        cycle(1'b0, 1'b0, 16'h0000, 2'b00);

`ifdef MY_DMUX_STREAM_STATS_EN
        // Preload the counter to FFFE, then walk it across the wrap
        begin
            logic s;
            s = 1'b0;
            while (mcount != 16'hFFFE) begin
                cycle(1'b1, s, 16'(mcount), 2'b11);
                s = ~s;
            end
        end
        check("cnt_fffe", 64'(xfer_count), 64'h0000_0000_0000_FFFE);
        cycle(1'b1, 1'b0, 16'hC0DE, 2'b11);
        check("cnt_ffff", 64'(xfer_count), 64'h0000_0000_0000_FFFF);
        cycle(1'b0, 1'b0, 16'h0000, 2'b00);
        cycle(1'b1, 1'b0, 16'hDEAD, 2'b10);
        check("cnt_blocked", 64'(xfer_count), 64'h0000_0000_0000_FFFF);
        cycle(1'b1, 1'b1, 16'hCAFE, 2'b10);
        check("cnt_0000", 64'(xfer_count), 64'h0);
        cycle(1'b1, 1'b0, 16'hF00D, 2'b01);
        check("cnt_0001", 64'(xfer_count), 64'h1);
        cycle(1'b0, 1'b0, 16'h0000, 2'b00);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
